// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch/data request ports and unified-memory port of the arbiter
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ack;
  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic [DATA_W-1:0] dm_rdata;
  logic              dm_ack;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              stall_if;
  logic              stall_mem;
  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    output if_rdata, if_ack, dm_rdata, dm_ack, mem_en, mem_we, mem_addr, mem_wdata,
           stall_if, stall_mem
  );
  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    input  if_rdata, if_ack, dm_rdata, dm_ack, mem_en, mem_we, mem_addr, mem_wdata,
           stall_if, stall_mem
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one fixed-latency memory between IF and MEM stages, dm-priority with IF anti-starvation
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input logic              i_clk,
  input logic              i_rst,
  mem_port_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int SW = $clog2(STARVE_MAX + 1);
  state_t            r_state, w_next;
  logic              r_owner;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata, r_if_rdata, r_dm_rdata;
  logic [CW-1:0]     r_cnt;
  logic [SW-1:0]     r_starve;
  logic              w_any, w_grant_dm, w_starved;
  assign w_any      = bus.if_req | bus.dm_req;
  assign w_starved  = bus.if_req & (r_starve == SW'(STARVE_MAX));
  assign w_grant_dm = bus.dm_req & ~w_starved;
  always_ff @(posedge i_clk) r_state <= i_rst ? IDLE : w_next;
  always_comb begin
    w_next      = r_state;
    bus.mem_en  = 1'b0;
    bus.mem_we  = 1'b0;
    bus.if_ack  = 1'b0;
    bus.dm_ack  = 1'b0;
    case (r_state)
      IDLE:  w_next = w_any ? ISSUE : IDLE;
      ISSUE: begin
        w_next     = WAIT;
        bus.mem_en = 1'b1;
        bus.mem_we = r_we;
      end
      WAIT:  w_next = (r_cnt == '0) ? RESP : WAIT;
      RESP:  begin
        w_next     = IDLE;
        bus.if_ack = ~r_owner;
        bus.dm_ack = r_owner;
      end
    endcase
  end
  // r_owner: 1 = data port owns the current transaction, 0 = fetch port
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_owner    <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_cnt      <= '0;
      r_starve   <= '0;
      r_if_rdata <= '0;
      r_dm_rdata <= '0;
    end else begin
      if (r_state == IDLE && w_any) begin
        r_owner  <= w_grant_dm;
        r_we     <= w_grant_dm & bus.dm_we;
        r_addr   <= w_grant_dm ? bus.dm_addr : bus.if_addr;
        r_wdata  <= w_grant_dm ? bus.dm_wdata : '0;
        r_starve <= !w_grant_dm ? '0 :
                    (bus.if_req && r_starve != SW'(STARVE_MAX)) ? r_starve + 1'b1 : r_starve;
      end
      if (r_state == ISSUE) r_cnt <= CW'(MEM_LAT - 1);
      if (r_state == WAIT && r_cnt != '0) r_cnt <= r_cnt - 1'b1;
      if (r_state == WAIT && r_cnt == '0 && !r_we && r_owner) r_dm_rdata <= bus.mem_rdata;
      if (r_state == WAIT && r_cnt == '0 && !r_owner) r_if_rdata <= bus.mem_rdata;
    end
  end
  assign bus.mem_addr  = r_addr;
  assign bus.mem_wdata = r_wdata;
  assign bus.if_rdata  = r_if_rdata;
  assign bus.dm_rdata  = r_dm_rdata;
  assign bus.stall_if  = bus.if_req & ~bus.if_ack;
  assign bus.stall_mem = bus.dm_req & ~bus.dm_ack;
endmodule
